// File: rtl/uart_pkt_tx_pkg.sv
// rtl/uart_pkt_tx_pkg.sv - shared constants and FSM encoding for the UART packet framer
// Contents: TX FIFO count width, sync byte, CRC-8 polynomial, 3-bit framer state enum.
package uart_pkt_tx_pkg;

    localparam int         TF_COUNT_W    = 5;
    localparam logic [7:0] PKT_SYNC      = 8'h7E;
    localparam logic [7:0] PKT_CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHECK = 3'd4
    } pkt_state_t;

endpackage

// File: rtl/uart_pkt_crc8.sv
// rtl/uart_pkt_crc8.sv - one-byte CRC-8 step (poly 0x07, MSB first, no reflection)
// Ports: i_crc  - running CRC value
//        i_byte - byte to fold in
//        o_crc  - CRC after folding i_byte
module uart_pkt_crc8
    import uart_pkt_tx_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic [7:0] i_byte,
    output logic [7:0] o_crc
);

    logic [7:0] w_c;

    always_comb begin
        w_c = i_crc ^ i_byte;
        for (int i = 0; i < 8; i++) begin
            w_c = w_c[7] ? ({w_c[6:0], 1'b0} ^ PKT_CRC8_POLY) : {w_c[6:0], 1'b0};
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/uart_pkt_tx.sv
// rtl/uart_pkt_tx.sv - packet framer feeding the UART TX FIFO: SYNC, LEN, payload, CHECK
// Build option: UART_PKT_CRC8_EN selects CRC-8 for CHECK; otherwise two's-complement sum.
// Ports: clk, rst_n (async, active-low)
//        pkt_start/pkt_len - frame request and payload length (1..255), sampled in IDLE
//        pkt_data/pkt_valid/pkt_ready - payload byte handshake
//        tf_count - TX FIFO fill level; tdr/tf_push - registered byte and push strobe
//        busy, pkt_done, pkt_err - frame status
module uart_pkt_tx
    import uart_pkt_tx_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = PKT_SYNC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pkt_start,
    input  logic [7:0]            pkt_len,
    input  logic [7:0]            pkt_data,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [TF_COUNT_W-1:0] tf_count,
    output logic [7:0]            tdr,
    output logic                  tf_push,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  pkt_err
);

    localparam logic [TF_COUNT_W:0] DEPTH_L = (TF_COUNT_W + 1)'(FIFO_DEPTH);

    pkt_state_t r_state, w_state_nxt;
    logic [7:0] r_rem, w_rem_nxt;
    logic [7:0] r_len, w_len_nxt;
    logic [7:0] r_chk, w_chk_nxt;
    logic [7:0] r_tdr, w_tdr_nxt;
    logic       r_push, w_push_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       r_err, w_err_nxt;

    logic       w_slot;
    logic [7:0] w_fold_byte;
    logic [7:0] w_chk_fold;
    logic [7:0] w_chk_byte;

    // A push is never decided in the cycle a push is visible, so tf_count
    // has already absorbed the previous push when it is compared here.
    assign w_slot      = !r_push && ({1'b0, tf_count} < DEPTH_L);
    assign w_fold_byte = (r_state == ST_LEN) ? r_len : pkt_data;

`ifdef UART_PKT_CRC8_EN
    uart_pkt_crc8 u_crc8 (
        .i_crc  (r_chk),
        .i_byte (w_fold_byte),
        .o_crc  (w_chk_fold)
    );
    assign w_chk_byte = r_chk;
`else
    assign w_chk_fold = r_chk + w_fold_byte;
    // Negated running sum makes LEN + payload + CHECK == 0 mod 256.
    assign w_chk_byte = 8'd0 - r_chk;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_len_nxt   = r_len;
        w_chk_nxt   = r_chk;
        w_tdr_nxt   = r_tdr;
        w_push_nxt  = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        pkt_ready   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (pkt_start) begin
                    if (pkt_len == 8'd0) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_len_nxt   = pkt_len;
                        w_rem_nxt   = pkt_len;
                        w_chk_nxt   = 8'd0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ST_SYNC;
                    end
                end
            end
            ST_SYNC: begin
                if (w_slot) begin
                    w_tdr_nxt   = SYNC_BYTE;
                    w_push_nxt  = 1'b1;
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_slot) begin
                    w_tdr_nxt   = r_len;
                    w_push_nxt  = 1'b1;
                    w_chk_nxt   = w_chk_fold;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                pkt_ready = w_slot;
                if (pkt_valid && w_slot) begin
                    w_tdr_nxt  = pkt_data;
                    w_push_nxt = 1'b1;
                    w_chk_nxt  = w_chk_fold;
                    w_rem_nxt  = r_rem - 8'd1;
                    if (r_rem == 8'd1) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (w_slot) begin
                    w_tdr_nxt   = w_chk_byte;
                    w_push_nxt  = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // A start request while a frame is in flight is refused, not queued.
        if (pkt_start && (r_state != ST_IDLE)) begin
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rem   <= 8'd0;
            r_len   <= 8'd0;
            r_chk   <= 8'd0;
            r_tdr   <= 8'd0;
            r_push  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_len   <= w_len_nxt;
            r_chk   <= w_chk_nxt;
            r_tdr   <= w_tdr_nxt;
            r_push  <= w_push_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign tdr      = r_tdr;
    assign tf_push  = r_push;
    assign busy     = r_busy;
    assign pkt_done = r_done;
    assign pkt_err  = r_err;

endmodule

// File: tb/tb_uart_pkt_tx.sv
// tb/tb_uart_pkt_tx.sv - scoreboard testbench for uart_pkt_tx
module tb_uart_pkt_tx;
    import uart_pkt_tx_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  pkt_start;
    logic [7:0]            pkt_len;
    logic [7:0]            pkt_data;
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [TF_COUNT_W-1:0] tf_count;
    logic [7:0]            tdr;
    logic                  tf_push;
    logic                  busy;
    logic                  pkt_done;
    logic                  pkt_err;

    uart_pkt_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pkt_start (pkt_start),
        .pkt_len   (pkt_len),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .tf_count  (tf_count),
        .tdr       (tdr),
        .tf_push   (tf_push),
        .busy      (busy),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] pl[$];
    logic       prev_push = 1'b0;
    int         n_checks  = 0;
    int         n_errors  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ b[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] frame_check(input logic [7:0] d[$]);
        logic [7:0] c;
`ifdef UART_PKT_CRC8_EN
        c = crc8_byte(8'h00, 8'(d.size()));
        foreach (d[i]) c = crc8_byte(c, d[i]);
`else
        c = 8'(d.size());
        foreach (d[i]) c = c + d[i];
        c = 8'h00 - c;
`endif
        return c;
    endfunction

    always @(negedge clk) begin
        if (tf_push) begin
            check("b2b_push", {31'd0, prev_push}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_push", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("tdr", {24'd0, tdr}, {24'd0, mon_e.b});
                check("pkt_done", {31'd0, pkt_done}, {31'd0, mon_e.last});
                check("busy_at_push", {31'd0, busy}, {31'd0, !mon_e.last});
            end
        end else if (pkt_done) begin
            check("done_without_push", 32'd1, 32'd0);
        end
        prev_push = tf_push;
    end

    task automatic send_frame(input logic [7:0] d[$], input int stall_at,
                              input bit busy_err, input int abort_at);
        logic [7:0] len;
        logic       acc;
        int         waited;
        len = 8'(d.size());
        sb.push_back('{b: 8'h7E, last: 1'b0});
        sb.push_back('{b: len, last: 1'b0});
        foreach (d[i]) sb.push_back('{b: d[i], last: 1'b0});
        sb.push_back('{b: frame_check(d), last: 1'b1});

        pkt_len   = len;
        pkt_start = 1'b1;
        @(posedge clk); #1;
        pkt_start = 1'b0;
        check("busy_set", {31'd0, busy}, 32'd1);

        if (busy_err) begin
            pkt_start = 1'b1;
            pkt_len   = 8'd9;
            @(posedge clk); #1;
            pkt_start = 1'b0;
            @(negedge clk);
            check("err_while_busy", {31'd0, pkt_err}, 32'd1);
            check("busy_held", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end

        for (int i = 0; i < d.size(); i++) begin
            pkt_data  = d[i];
            pkt_valid = 1'b1;
            if (i == abort_at) begin
                @(posedge clk); #2;
                rst_n = 1'b0;
                #1;
                check("rst_tdr", {24'd0, tdr}, 32'd0);
                check("rst_push", {31'd0, tf_push}, 32'd0);
                check("rst_ready", {31'd0, pkt_ready}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_done", {31'd0, pkt_done}, 32'd0);
                check("rst_err", {31'd0, pkt_err}, 32'd0);
                sb.delete();
                pkt_valid = 1'b0;
                #1;
                rst_n = 1'b1;
                return;
            end
            if (i == stall_at) begin
                tf_count = 5'd16;
                @(posedge clk); #1;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    check("stall_push", {31'd0, tf_push}, 32'd0);
                    check("stall_ready", {31'd0, pkt_ready}, 32'd0);
                    @(posedge clk); #1;
                end
                tf_count = 5'd0;
            end
            waited = 0;
            do begin
                @(negedge clk);
                acc = pkt_ready;
                @(posedge clk); #1;
                waited++;
            end while (!acc && waited < 100);
            if (!acc) check("handshake_timeout", 32'd0, 32'd1);
        end
        pkt_valid = 1'b0;

        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        check("frame_drained", sb.size(), 32'd0);
        @(posedge clk); #1;
        check("busy_clear", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        pkt_start = 1'b0;
        pkt_len   = 8'd0;
        pkt_data  = 8'd0;
        pkt_valid = 1'b0;
        tf_count  = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tdr", {24'd0, tdr}, 32'd0);
        check("reset_push", {31'd0, tf_push}, 32'd0);
        check("reset_ready", {31'd0, pkt_ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, pkt_done}, 32'd0);
        check("reset_err", {31'd0, pkt_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame: 7E 03 01 02 03 CHECK
        pl = {8'h01, 8'h02, 8'h03};
        send_frame(pl, -1, 1'b0, -1);

        // Zero-length request is rejected
        pkt_len   = 8'd0;
        pkt_start = 1'b1;
        @(posedge clk); #1;
        pkt_start = 1'b0;
        check("len0_err", {31'd0, pkt_err}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        check("len0_push", {31'd0, tf_push}, 32'd0);
        @(posedge clk); #1;
        check("len0_err_pulse", {31'd0, pkt_err}, 32'd0);
        check("len0_idle_push", {31'd0, tf_push}, 32'd0);

        // Start while busy: error pulse, frame untouched
        pl = {8'h10, 8'h20, 8'h30, 8'h40};
        send_frame(pl, -1, 1'b1, -1);

        // FIFO full for 20 cycles mid-payload
        pl = {8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
        send_frame(pl, 3, 1'b0, -1);

        // Reset during the second payload byte, then a fresh 7E 01 AA CHECK frame
        pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(pl, -1, 1'b0, 1);
        @(posedge clk); #1;
        pl = {8'hAA};
        send_frame(pl, -1, 1'b0, -1);

        // Maximum length frame with random payload
        pl = {};
        for (int i = 0; i < 255; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(pl, -1, 1'b0, -1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
